// File: rtl/mds_pipe.sv
// Memory data register with a timed multi-channel bus read and an output
// select mux. Encoding of dbg_state: 0 = IDLE, 1 = WAIT, 2 = DONE.
module mds_pipe #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 2,
    parameter int TIMEOUT = 255,
    localparam int SW     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      ob,
    input  logic                  mdsel,
    input  logic                  memdrive,
    input  logic                  loadmd,
    input  logic [SW-1:0]         src_sel,
    input  logic                  loadob,
    input  logic [NSRC*WIDTH-1:0] bus_data,
    input  logic [NSRC-1:0]       bus_valid,
    output logic [NSRC-1:0]       bus_ready,
    output logic [WIDTH-1:0]      md,
    output logic                  md_par,
    output logic [WIDTH-1:0]      mds,
    output logic                  busy,
    output logic                  md_done,
    output logic                  nxm,
    output logic [1:0]            dbg_state
);

    // Bus handshake: a read on channel c completes on the rising edge where
    // bus_ready[c] and bus_valid[c] are both 1; bus_ready is only raised in WAIT.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] md_q, md_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [SW-1:0]    cur_src_q, cur_src_d;
    logic             nxm_q, nxm_d;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            md_q      <= '0;
            cnt_q     <= '0;
            cur_src_q <= '0;
            nxm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_q      <= md_d;
            cnt_q     <= cnt_d;
            cur_src_q <= cur_src_d;
            nxm_q     <= nxm_d;
        end
    end

    // An out-of-range cur_src matches no channel, so it can only end in a timeout.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(cur_src_q) == i) begin
                sel_valid = bus_valid[i];
                sel_data  = bus_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        md_d      = md_q;
        cnt_d     = cnt_q;
        cur_src_d = cur_src_q;
        nxm_d     = 1'b0;
        bus_ready = '0;
        case (state_q)
            IDLE: begin
                if (loadob) md_d = ob;
                if (loadmd) begin
                    cur_src_d = src_sel;
                    cnt_d     = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                for (int i = 0; i < NSRC; i++) begin
                    bus_ready[i] = (int'(cur_src_q) == i);
                end
                // A handshake on the timeout cycle still completes the read.
                if (sel_valid) begin
                    md_d    = sel_data;
                    state_d = DONE;
                end else if (cnt_q == TO) begin
                    state_d = IDLE;
                    nxm_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign md        = md_q;
    assign md_par    = ~^md_q;
    assign mds       = mdsel ? ob : (memdrive ? md_q : '0);
    assign busy      = (state_q == WAIT);
    assign md_done   = (state_q == DONE);
    assign nxm       = nxm_q;
    assign dbg_state = state_q;

endmodule
